// File: rtl/control_sequencer_if.sv
// Control-unit <-> datapath bundle: instruction fields in, strobes/selects/status out.
// With ILLEGAL_TRAP_EN defined the bundle also carries the illegal-instruction flag.
interface control_sequencer_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        rw;
  logic        mw;
  logic        rdst;
  logic        asrc;
  logic        mtg;
  logic        pcsrc;
  logic        jmp;
  logic        jr;
  logic [4:0]  alu_op;
  logic        halt;
  logic        stopped;
  logic [31:0] retired_count;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  modport master (
    input  opcode, funct,
`ifdef ILLEGAL_TRAP_EN
    output illegal,
`endif
    output rw, mw, rdst, asrc, mtg, pcsrc, jmp, jr, alu_op, halt, stopped, retired_count
  );

  modport slave (
    output opcode, funct,
`ifdef ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  rw, mw, rdst, asrc, mtg, pcsrc, jmp, jr, alu_op, halt, stopped, retired_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALTED with a retire counter.
// Optional feature macro ILLEGAL_TRAP_EN traps unknown opcodes / bad R-type functs into HALTED.
module control_sequencer (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  control_sequencer_if.master   bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED} state_e;
  typedef enum logic [3:0] {C_RTYPE, C_JR, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_UNK} class_e;

  function automatic class_e classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn == FN_JR) ? C_JR : C_RTYPE;
      OP_ADDI:  return C_ADDI;
      OP_LW:    return C_LW;
      OP_SW:    return C_SW;
      OP_BEQ:   return C_BEQ;
      OP_J:     return C_J;
      OP_HALT:  return C_HALT;
      default:  return C_UNK;
    endcase
  endfunction

`ifdef ILLEGAL_TRAP_EN
  // The ALU-op group of R-type functs is the funct[5]=1 block (add = 6'b100000); jr is classed apart.
  function automatic logic is_illegal(class_e c, logic fn5);
    return (c == C_UNK) || (c == C_RTYPE && !fn5);
  endfunction
`endif

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  fn_q, fn_d;
  logic [31:0] cnt_q, cnt_d;
  logic        retire;
  class_e      dec_cls, cur_cls;

  // DECODE steers on the live instruction; every later state uses the latched copy.
  assign dec_cls = classify(bus.opcode, bus.funct);
  assign cur_cls = classify(op_q, fn_q);
  assign cnt_d   = cnt_q + {31'd0, retire};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        fn_d = bus.funct;
        if (dec_cls == C_HALT) state_d = S_HALTED;
`ifdef ILLEGAL_TRAP_EN
        else if (is_illegal(dec_cls, bus.funct[5])) state_d = S_HALTED;
`endif
        else state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cur_cls)
          C_RTYPE, C_ADDI: state_d = S_WB;
          C_LW, C_SW:      state_d = S_MEM;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM:    state_d = (cur_cls == C_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire      = 1'b0;
    bus.rdst    = 1'b0;
    bus.asrc    = 1'b0;
    bus.mtg     = 1'b0;
    bus.alu_op  = '0;
    case (state_q)
      S_EXEC:  retire = cur_cls inside {C_BEQ, C_J, C_JR, C_UNK};
      S_MEM:   retire = (cur_cls == C_SW);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      bus.rdst = cur_cls inside {C_RTYPE, C_JR};
      bus.asrc = cur_cls inside {C_ADDI, C_LW, C_SW};
      bus.mtg  = (cur_cls == C_LW);
      case (cur_cls)
        C_RTYPE, C_JR:      bus.alu_op = fn_q[4:0];
        C_ADDI, C_LW, C_SW: bus.alu_op = ALU_ADD;
        C_BEQ:              bus.alu_op = ALU_SUB;
        default:            bus.alu_op = '0;
      endcase
    end
    bus.rw      = (state_q == S_WB);
    bus.mw      = (state_q == S_MEM) && (cur_cls == C_SW);
    bus.halt    = !retire;
    bus.pcsrc   = retire && (cur_cls == C_BEQ);
    bus.jmp     = retire && (cur_cls == C_J);
    bus.jr      = retire && (cur_cls == C_JR);
    bus.stopped = (state_q == S_HALTED);
  end

  assign bus.retired_count = cnt_q;

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal = (state_q == S_HALTED) && is_illegal(cur_cls, fn_q[5]);
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table-driven instruction vectors with a
// per-cycle expectation queue, plus hand-written reset-abort and HALT sequences.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  control_sequencer_if bus ();
  control_sequencer dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.master));

  typedef struct packed {
    logic        halt, rw, mw, rdst, asrc, mtg, pcsrc, jmp, jr;
    logic [4:0]  alu;
    logic        stopped;
    logic [31:0] cnt;
  } out_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         len;
    int         rw_c;
    int         mw_c;
    logic       rdst, asrc, mtg;
    logic [4:0] alu;
    logic       pcs, jmp, jr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned model_cnt = 0;
  out_t        exp_q[$];
  vec_t        vecs[$];
  out_t        rst_exp;

  function automatic out_t sample();
    out_t o;
    o = '{halt: bus.halt, rw: bus.rw, mw: bus.mw, rdst: bus.rdst, asrc: bus.asrc,
          mtg: bus.mtg, pcsrc: bus.pcsrc, jmp: bus.jmp, jr: bus.jr, alu: bus.alu_op,
          stopped: bus.stopped, cnt: bus.retired_count};
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Called at a negedge with the sequencer in FETCH; returns at the next instruction's FETCH.
  task automatic run_vec(input vec_t v);
    out_t e;
    bus.opcode = v.op;
    bus.funct  = v.fn;
    for (int c = 1; c <= v.len; c++) begin
      e      = '0;
      e.halt = (c != v.len);
      e.rw   = (c == v.rw_c);
      e.mw   = (c == v.mw_c);
      if (c >= 3) begin
        e.rdst = v.rdst;
        e.asrc = v.asrc;
        e.mtg  = v.mtg;
        e.alu  = v.alu;
      end
      if (c == v.len) begin
        e.pcsrc = v.pcs;
        e.jmp   = v.jmp;
        e.jr    = v.jr;
      end
      e.cnt = model_cnt;
      exp_q.push_back(e);
    end
    for (int c = 1; c <= v.len; c++) begin
      #1 check($sformatf("%s_c%0d", v.name, c), sample(), exp_q.pop_front());
      @(negedge clk);
    end
    model_cnt++;
  endtask

  initial begin
    //              name    op     fn     len rw mw rdst asrc mtg  alu     pcs  jmp  jr
    vecs.push_back('{"add",  6'h00, 6'h20, 4, 4, 0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"lw",   6'h23, 6'h00, 5, 5, 0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sw",   6'h2b, 6'h00, 4, 0, 4, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"sub",  6'h00, 6'h22, 4, 4, 0, 1'b1, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"addi", 6'h08, 6'h15, 4, 4, 0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"beq",  6'h04, 6'h00, 3, 0, 0, 1'b0, 1'b0, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"j",    6'h02, 6'h00, 3, 0, 0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{"jr",   6'h00, 6'h08, 3, 0, 0, 1'b1, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0, 1'b1});
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back('{"unk",  6'h15, 6'h00, 3, 0, 0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0});
`endif
    rst_exp      = '0;
    rst_exp.halt = 1'b1;

    rst_n      = 1'b0;
    bus.opcode = '0;
    bus.funct  = '0;
    repeat (3) @(negedge clk);
    #1 check("reset", sample(), rst_exp);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort a store in MEM: reset must suppress the MW pulse and the retire.
    bus.opcode = 6'h2b;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    #1 check("sw_abort_reset", sample(), rst_exp);
    @(negedge clk);
    #1 check("sw_abort_hold", sample(), rst_exp);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[5]);

    // HALT: FETCH, DECODE, then frozen in HALTED regardless of later instructions.
    begin
      out_t e;
      bus.opcode = 6'h3f;
      for (int c = 1; c <= 23; c++) begin
        e         = rst_exp;
        e.cnt     = model_cnt;
        e.stopped = (c >= 3);
        exp_q.push_back(e);
      end
      for (int c = 1; c <= 23; c++) begin
        #1 check($sformatf("halt_c%0d", c), sample(), exp_q.pop_front());
        @(negedge clk);
        bus.opcode = (c >= 3) ? 6'h00 : 6'h3f;
        bus.funct  = 6'h20;
      end
    end
    rst_n = 1'b0;
    model_cnt = 0;
    #1 check("halt_reset", sample(), rst_exp);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

`ifdef ILLEGAL_TRAP_EN
    bus.opcode = 6'h15;
    repeat (2) @(negedge clk);
    #1 begin
      checks++;
      if (bus.illegal !== 1'b1 || bus.stopped !== 1'b1 || bus.halt !== 1'b1
          || bus.retired_count !== model_cnt) begin
        errors++;
        $display("FAIL illegal_trap got illegal=%b stopped=%b halt=%b cnt=%0d expected 1 1 1 %0d",
                 bus.illegal, bus.stopped, bus.halt, bus.retired_count, model_cnt);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
